// File: rtl/mini_tpu_if.sv
// mini_tpu_if: instruction bus into the systolic engine and its registered result byte back out.
interface mini_tpu_if;
  logic [15:0] instruction;
  logic [7:0]  result;
  modport master (output instruction, input result);
  modport slave  (input instruction, output result);
endinterface

// File: rtl/mini_tpu.sv
// mini_tpu: 4x4 output-stationary systolic matrix-multiply engine, C = A x B on 8-bit unsigned operands.
module mini_tpu (
  input logic       clk,
  input logic       rst,
  mini_tpu_if.slave bus
);
  localparam int N = 4;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RUN = 2'b01, OP_LOAD = 2'b10, OP_STORE = 2'b11} op_e;
  op_e        op;
  logic [1:0] sel, row, col;
  logic [7:0] data;
  logic [N-1:0][N-1:0][7:0]  a_mem_q, a_mem_d, b_mem_q, b_mem_d;
  logic [N-1:0][N-1:0][7:0]  a_pipe_q, a_pipe_d, b_pipe_q, b_pipe_d, a_src, b_src;
  logic [N-1:0][N-1:0][15:0] acc_q, acc_d;
  logic [N-1:0][7:0]         edge_a, edge_b;
  logic [3:0]                t_q, t_d;
  logic [7:0]                result_q, result_d;
  assign op         = op_e'(bus.instruction[15:14]);
  assign sel        = bus.instruction[13:12];
  assign row        = bus.instruction[11:10];
  assign col        = bus.instruction[9:8];
  assign data       = bus.instruction[7:0];
  assign bus.result = result_q;
  // Skewed edge feed: row i / col j starts i / j steps late, so operand k meets PE(i,j) at t = i+j+k.
  always_comb begin
    edge_a = '0;
    edge_b = '0;
    a_src  = '0;
    b_src  = '0;
    for (int i = 0; i < N; i++) begin
      edge_a[i] = (t_q >= 4'(i) && t_q <= 4'(i + 3)) ? a_mem_q[i][2'(t_q - 4'(i))] : 8'h00;
      edge_b[i] = (t_q >= 4'(i) && t_q <= 4'(i + 3)) ? b_mem_q[2'(t_q - 4'(i))][i] : 8'h00;
      a_src[i][0] = edge_a[i];
      b_src[0][i] = edge_b[i];
      for (int j = 1; j < N; j++) begin
        a_src[i][j] = a_pipe_q[i][j-1];
        b_src[j][i] = b_pipe_q[j-1][i];
      end
    end
  end
  always_comb begin
    a_mem_d  = a_mem_q;
    b_mem_d  = b_mem_q;
    a_pipe_d = a_pipe_q;
    b_pipe_d = b_pipe_q;
    acc_d    = acc_q;
    t_d      = t_q;
    result_d = result_q;
    if (op == OP_LOAD) begin
      if (sel == 2'b00) a_mem_d[row][col] = data;
      if (sel == 2'b10) b_mem_d[row][col] = data;
      a_pipe_d = '0;
      b_pipe_d = '0;
      acc_d    = '0;
      t_d      = '0;
    end else if (op == OP_RUN) begin
      a_pipe_d = a_src;
      b_pipe_d = b_src;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc_d[i][j] = acc_q[i][j] + 16'(a_src[i][j]) * 16'(b_src[i][j]);
      t_d = (t_q == 4'd10) ? t_q : t_q + 4'd1;
    end else if (op == OP_STORE) begin
      result_d = acc_q[row][col][7:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mem_q  <= '0;
      b_mem_q  <= '0;
      a_pipe_q <= '0;
      b_pipe_q <= '0;
      acc_q    <= '0;
      t_q      <= '0;
      result_q <= '0;
    end else begin
      a_mem_q  <= a_mem_d;
      b_mem_q  <= b_mem_d;
      a_pipe_q <= a_pipe_d;
      b_pipe_q <= b_pipe_d;
      acc_q    <= acc_d;
      t_q      <= t_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_mini_tpu.sv
// tb_mini_tpu: directed and random checks of mini_tpu against a dot-product reference model.
module tb_mini_tpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mini_tpu_if bus ();
  mini_tpu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int mA [4][4];
  int mB [4][4];
  int runs;
  logic [7:0] mres;
  int checks = 0;
  int errors = 0;
  // Product k of C[r][c] lands in PE(r,c) on RUN step r+c+k, so after `runs` steps only k < runs-r-c count.
  function automatic logic [7:0] exp_c(input int r, input int c);
    int s = 0;
    for (int k = 0; k < 4; k++)
      if (r + c + k < runs) s += mA[r][k] * mB[k][c];
    return 8'(s);
  endfunction
  task automatic model_clear();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mA[r][c] = 0;
        mB[r][c] = 0;
      end
    runs = 0;
    mres = 8'h00;
  endtask
  task automatic exec(input logic [1:0] op, input logic [1:0] sel, input logic [1:0] row,
                      input logic [1:0] col, input logic [7:0] d);
    bus.instruction = {op, sel, row, col, d};
    @(posedge clk);
    #1;
    case (op)
      2'b10: begin
        if (sel == 2'b00) mA[row][col] = int'(d);
        if (sel == 2'b10) mB[row][col] = int'(d);
        runs = 0;
      end
      2'b01: if (runs < 100) runs++;
      2'b11: mres = exp_c(int'(row), int'(col));
      default: ;
    endcase
  endtask
  task automatic chk(input string tag);
    checks++;
    assert (bus.result === mres) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, bus.result, mres);
    end
  endtask
  task automatic chk_const(input string tag, input logic [7:0] want);
    checks++;
    assert (bus.result === want) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, bus.result, want);
    end
  endtask
  task automatic store_chk(input int r, input int c, input string tag);
    exec(2'b11, 2'b00, 2'(r), 2'(c), 8'h00);
    chk($sformatf("%s_%0d%0d", tag, r, c));
  endtask
  task automatic store_all(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) store_chk(r, c, tag);
  endtask
  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) exec(2'b01, 2'(i), 2'(i), 2'(i), 8'(i * 37));
  endtask
  task automatic load_seq(input int bmode);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        exec(2'b10, 2'b00, 2'(r), 2'(c), 8'(r * 4 + c + 1));
        exec(2'b10, 2'b10, 2'(r), 2'(c), bmode ? 8'(r * 4 + c + 1) : ((r == c) ? 8'h01 : 8'h00));
      end
  endtask
  initial begin
    bus.instruction = 16'h0000;
    model_clear();
    #23 rst = 1'b0;
    #1;
    chk("reset_result");
    store_chk(2, 1, "store_no_run");
    store_chk(3, 3, "store_no_run");
    // A = 1..16 row-major, B = identity
    load_seq(0);
    run_n(10);
    store_all("ident");
    chk_const("ident_c33_lit", 8'h10);
    // A = B = 1..16, partial then complete then saturated
    load_seq(1);
    run_n(9);
    store_all("partial9");
    run_n(1);
    store_chk(0, 0, "full");
    chk_const("full_c00_lit", 8'h5A);
    store_chk(3, 3, "full");
    chk_const("full_c33_lit", 8'h58);
    exec(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
    chk("hold_nop");
    exec(2'b01, 2'b00, 2'b00, 2'b00, 8'h00);
    chk("hold_run");
    run_n(4);
    store_all("sat15");
    // sel 01/11 load nothing but still clear the array
    exec(2'b10, 2'b01, 2'b01, 2'b01, 8'hFF);
    chk("hold_load");
    exec(2'b10, 2'b11, 2'b10, 2'b10, 8'hEE);
    store_all("cleared");
    run_n(10);
    store_all("rerun");
    // random matrices with NOPs interleaved between RUNs
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          exec(2'b10, 2'b00, 2'(r), 2'(c), 8'($urandom));
          exec(2'b10, 2'b10, 2'(r), 2'(c), 8'($urandom));
        end
      for (int s = 0; s < 12; s++) begin
        exec(2'b01, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        if ($urandom_range(0, 1) == 1) exec(2'b00, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        if ($urandom_range(0, 2) == 0) store_chk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd_mid");
      end
      store_all("rnd_full");
    end
    // async reset in the middle of RUN step 5
    load_seq(1);
    run_n(5);
    bus.instruction = 16'h4000;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_mid_run");
    #1 rst = 1'b0;
    store_all("after_rst");
    load_seq(1);
    run_n(10);
    store_all("reload");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
